calu_sequencer: RTL and testbench

CALU_SEQUENCER -- requirements
Module: calu_sequencer

---
 rtl/calu_sequencer_pkg.sv | 57 +++++
 rtl/calu_sequencer.sv | 160 ++++++++++++++++
 tb/tb_calu_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calu_sequencer_pkg.sv
// Shared definitions for the CALU command sequencer: widths, flag bit
// positions, opcode encodings, FSM state type and the command payload
// presented to the CALU.
package calu_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 12;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ERR_W  = 8;

    // Flag bit positions inside calu_flags / rsp_flags / sticky_flags
    localparam int unsigned FLAG_CR   = 11;
    localparam int unsigned FLAG_CI   = 10;
    localparam int unsigned FLAG_DVFR = 9;
    localparam int unsigned FLAG_DVFI = 8;
    localparam int unsigned FLAG_ZER  = 7;
    localparam int unsigned FLAG_ZEI  = 6;
    localparam int unsigned FLAG_ZR   = 5;
    localparam int unsigned FLAG_ZI   = 4;
    localparam int unsigned FLAG_OR   = 3;
    localparam int unsigned FLAG_OI   = 2;
    localparam int unsigned FLAG_NR   = 1;
    localparam int unsigned FLAG_NI   = 0;

    // Flags that mark a result as erroneous (divide overflow / divide by zero)
    localparam logic [FLAG_W-1:0] ERR_MASK =
        FLAG_W'((1 << FLAG_DVFR) | (1 << FLAG_DVFI) | (1 << FLAG_ZER) | (1 << FLAG_ZEI));

    // CALU opcodes
    localparam logic [OPC_W-1:0] OP_CADD = 4'h0;
    localparam logic [OPC_W-1:0] OP_CSUB = 4'h1;
    localparam logic [OPC_W-1:0] OP_CMUL = 4'h2;
    localparam logic [OPC_W-1:0] OP_CDIV = 4'h3;
    localparam logic [OPC_W-1:0] OP_CINC = 4'h4;
    localparam logic [OPC_W-1:0] OP_CDEC = 4'h5;
    localparam logic [OPC_W-1:0] OP_CMAG = 4'h6;
    localparam logic [OPC_W-1:0] OP_CONJ = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Operation word held stable on the calu_* outputs
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] z1;
        logic [DATA_W-1:0] z2;
    } calu_cmd_t;

    function automatic logic is_error(input logic [FLAG_W-1:0] flags);
        return |(flags & ERR_MASK);
    endfunction

endpackage

// File: rtl/calu_sequencer.sv
// CALU command sequencer: accepts one command at a time, presents it to an
// external CALU, waits SETTLE_CYCLES for the datapath to settle, captures
// the result into a response register and the accumulator, and keeps
// sticky flags plus a saturating error count.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_opcode/cmd_z1/cmd_z2          command payload
//   cmd_use_acc                       take Z1 from the accumulator
//   calu_opcode/calu_z1/calu_z2       registered operands to the CALU
//   calu_zout/calu_flags              CALU result and flags
//   rsp_valid/rsp_ready               response handshake
//   rsp_z/rsp_flags                   captured result and flags
//   acc                               accumulator (last captured result)
//   sticky_flags/sticky_clr           accumulated flags and their clear
//   err_count                         saturating count of error results
module calu_sequencer
    import calu_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPC_W-1:0]  cmd_opcode,
    input  logic [DATA_W-1:0] cmd_z1,
    input  logic [DATA_W-1:0] cmd_z2,
    input  logic              cmd_use_acc,
    output logic [OPC_W-1:0]  calu_opcode,
    output logic [DATA_W-1:0] calu_z1,
    output logic [DATA_W-1:0] calu_z2,
    input  logic [DATA_W-1:0] calu_zout,
    input  logic [FLAG_W-1:0] calu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_z,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic [DATA_W-1:0] acc,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              sticky_clr,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    calu_cmd_t         cmd_q,       cmd_d;
    logic              ready_q,     ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_z_q,     rsp_z_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic [DATA_W-1:0] acc_q,       acc_d;
    logic [FLAG_W-1:0] sticky_q,    sticky_d;
    logic [ERR_W-1:0]  err_q,       err_d;
    logic              capture_c;
    logic [FLAG_W-1:0] sticky_base_c;

    // Result is captured on the last settle cycle of WAIT
    always_comb begin
        capture_c = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
    end

    // Clear takes effect before a coincident capture merges its flags
    always_comb begin
        sticky_base_c = sticky_clr ? '0 : sticky_q;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
        rsp_flags_d = rsp_flags_q;
        acc_d       = acc_q;
        sticky_d    = sticky_base_c;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.opcode = cmd_opcode;
                    cmd_d.z1     = cmd_use_acc ? acc_q : cmd_z1;
                    cmd_d.z2     = cmd_z2;
                    cnt_d        = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (capture_c) begin
                    rsp_z_d     = calu_zout;
                    rsp_flags_d = calu_flags;
                    acc_d       = calu_zout;
                    rsp_valid_d = 1'b1;
                    sticky_d    = sticky_base_c | calu_flags;
                    if (is_error(calu_flags) && (err_q != ERR_MAX)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= '0;
            rsp_flags_q <= '0;
            acc_q       <= '0;
            sticky_q    <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_flags_q <= rsp_flags_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign calu_opcode  = cmd_q.opcode;
    assign calu_z1      = cmd_q.z1;
    assign calu_z2      = cmd_q.z2;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_z        = rsp_z_q;
    assign rsp_flags    = rsp_flags_q;
    assign acc          = acc_q;
    assign sticky_flags = sticky_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_calu_sequencer.sv
// Bench for calu_sequencer: a behavioural CALU stand-in that only presents
// a valid result once its inputs have been stable for SETTLE_CYCLES, a
// transaction-level reference model compared every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_calu_sequencer;
    import calu_sequencer_pkg::*;

    localparam int unsigned S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [31:0] cmd_z1;
    logic [31:0] cmd_z2;
    logic        cmd_use_acc;
    logic [3:0]  calu_opcode;
    logic [31:0] calu_z1;
    logic [31:0] calu_z2;
    logic [31:0] calu_zout;
    logic [11:0] calu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_z;
    logic [11:0] rsp_flags;
    logic [31:0] acc;
    logic [11:0] sticky_flags;
    logic        sticky_clr;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    calu_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_z1      (cmd_z1),
        .cmd_z2      (cmd_z2),
        .cmd_use_acc (cmd_use_acc),
        .calu_opcode (calu_opcode),
        .calu_z1     (calu_z1),
        .calu_z2     (calu_z2),
        .calu_zout   (calu_zout),
        .calu_flags  (calu_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_z       (rsp_z),
        .rsp_flags   (rsp_flags),
        .acc         (acc),
        .sticky_flags(sticky_flags),
        .sticky_clr  (sticky_clr),
        .err_count   (err_count)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Toy CALU: returns {flags, z}
    function automatic logic [43:0] calu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [15:0] re, im;
        logic [11:0] f;
        f = '0;
        case (op)
            OP_CADD: begin re = a[31:16] + b[31:16]; im = a[15:0] + b[15:0]; end
            OP_CSUB: begin re = a[31:16] - b[31:16]; im = a[15:0] - b[15:0]; end
            OP_CINC: begin re = a[31:16] + 16'd1;    im = a[15:0] + 16'd1;    end
            OP_CDIV: begin
                re = (b[31:16] == 0) ? 16'd0 : a[31:16] / b[31:16];
                im = (b[15:0]  == 0) ? 16'd0 : a[15:0]  / b[15:0];
                f[7] = (b[31:16] == 0);
                f[6] = (b[15:0]  == 0);
                return {f, re, im};
            end
            default: begin
                re = a[31:16] ^ b[15:0]  ^ 16'h5A5A;
                im = a[15:0]  ^ b[31:16] ^ 16'h0F0F;
                f  = re[11:0] ^ im[11:0];
                return {f, re, im};
            end
        endcase
        f[1] = re[15];
        f[0] = im[15];
        f[5] = (re == 0);
        f[4] = (im == 0);
        return {f, re, im};
    endfunction

    // CALU stand-in: garbage until its inputs have been stable S cycles
    logic [67:0] last_calu;
    int          age = 0;
    task automatic calu_drive();
        logic [67:0] cur;
        logic [43:0] r;
        cur = {calu_opcode, calu_z1, calu_z2};
        if (cur !== last_calu) begin
            last_calu = cur;
            age = 1;
        end else if (age < 1000) begin
            age++;
        end
        r = calu_fn(calu_opcode, calu_z1, calu_z2);
        if (age >= S) {calu_flags, calu_zout} = r;
        else          {calu_flags, calu_zout} = ~r;
    endtask

    // Transaction-level reference model
    bit          m_known = 0;
    bit          m_busy, m_rv, m_accepted;
    int          m_wait, m_err;
    logic [3:0]  m_op;
    logic [31:0] m_z1, m_z2, m_rz, m_acc;
    logic [11:0] m_rf, m_sticky;

    task automatic model_update();
        bit hs, cap;
        logic [43:0] r;
        m_accepted = 0;
        if (rst) begin
            m_known = 1; m_busy = 0; m_rv = 0; m_wait = 0; m_err = 0;
            m_op = '0; m_z1 = '0; m_z2 = '0; m_rz = '0; m_acc = '0;
            m_rf = '0; m_sticky = '0;
        end else if (m_known) begin
            hs  = m_rv && rsp_ready;
            cap = 0;
            if (m_busy && !m_rv) begin
                m_wait++;
                cap = (m_wait == S);
            end
            if (sticky_clr) m_sticky = '0;
            if (cap) begin
                r     = calu_fn(m_op, m_z1, m_z2);
                m_rz  = r[31:0];
                m_rf  = r[43:32];
                m_acc = m_rz;
                m_rv  = 1;
                m_sticky = m_sticky | m_rf;
                if (((m_rf & 12'h3C0) != 0) && m_err < 255) m_err++;
            end
            if (hs) begin
                m_rv = 0;
                m_busy = 0;
            end else if (!m_busy && cmd_valid) begin
                m_busy = 1;
                m_wait = 0;
                m_op   = cmd_opcode;
                m_z1   = cmd_use_acc ? m_acc : cmd_z1;
                m_z2   = cmd_z2;
                m_accepted = 1;
            end
        end
    endtask

    task automatic compare();
        if (m_known) begin
            chk("cmd_ready",    32'(cmd_ready),    32'(!m_busy));
            chk("rsp_valid",    32'(rsp_valid),    32'(m_rv));
            chk("rsp_z",        rsp_z,             m_rz);
            chk("rsp_flags",    32'(rsp_flags),    32'(m_rf));
            chk("acc",          acc,               m_acc);
            chk("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
            chk("err_count",    32'(err_count),    32'(m_err));
            chk("calu_opcode",  32'(calu_opcode),  32'(m_op));
            chk("calu_z1",      calu_z1,           m_z1);
            chk("calu_z2",      calu_z2,           m_z2);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_update();
        compare();
        calu_drive();
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] z1, input logic [31:0] z2, input logic ua);
        int n;
        n = 0;
        cmd_opcode = op; cmd_z1 = z1; cmd_z2 = z2; cmd_use_acc = ua; cmd_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!m_accepted && n < 50);
        if (!m_accepted) chk("accept_timeout", 32'(n), 32'(0));
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            cycle();
            lat++;
        end
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [31:0] z1, input logic [31:0] z2,
                          input logic ua, output int lat);
        issue(op, z1, z2, ua);
        wait_rsp(lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_z1 = '0; cmd_z2 = '0;
        cmd_use_acc = 1'b0; rsp_ready = 1'b1; sticky_clr = 1'b0;
        calu_drive();
        cycle();
        cycle();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_acc",       acc,            32'd0);
        chk("rst_err",       32'(err_count), 32'd0);
        chk("rst_calu_z1",   calu_z1,        32'd0);
        rst = 1'b0;

        // Basic add and latency
        do_cmd(OP_CADD, 32'h0001_0002, 32'h0003_0004, 1'b0, lat);
        chk("cadd_latency", 32'(lat),       32'(S));
        chk("cadd_z",       rsp_z,          32'h0004_0006);
        chk("cadd_flags",   32'(rsp_flags), 32'h000);
        cycle();

        // Accumulate from reset
        rst = 1'b1; cycle(); rst = 1'b0;
        do_cmd(OP_CINC, 32'hDEAD_BEEF, 32'h0, 1'b1, lat);
        chk("acc_1", acc, 32'h0001_0001);
        cycle();
        do_cmd(OP_CINC, 32'hDEAD_BEEF, 32'h0, 1'b1, lat);
        chk("acc_2", acc, 32'h0002_0002);
        cycle();

        // Divide by zero
        do_cmd(OP_CDIV, 32'h0001_0001, 32'h0, 1'b0, lat);
        chk("cdiv_flags",  32'(rsp_flags),            32'h0C0);
        chk("cdiv_err",    32'(err_count),            32'd1);
        chk("cdiv_sticky", 32'(sticky_flags & 12'h0C0), 32'h0C0);
        cycle();

        // Backpressure: response held, new command refused
        rsp_ready = 1'b0;
        do_cmd(OP_CADD, 32'h0010_0020, 32'h0001_0001, 1'b0, lat);
        cmd_opcode = OP_CDIV; cmd_z1 = 32'h1234_5678; cmd_z2 = 32'h0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_rsp_z",     rsp_z,            32'h0011_0021);
            chk("bp_rsp_flags", 32'(rsp_flags),   32'h000);
            chk("bp_cmd_ready", 32'(cmd_ready),   32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid),   32'd1);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        cycle();
        chk("bp_calu_op",   32'(calu_opcode), 32'(OP_CADD));
        chk("bp_released",  32'(rsp_valid),   32'd0);

        // Sticky clear coincident with capture
        issue(OP_CSUB, 32'h0000_0000, 32'h0001_0001, 1'b0);
        for (int i = 0; i < int'(S) - 1; i++) cycle();
        sticky_clr = 1'b1;
        cycle();
        sticky_clr = 1'b0;
        chk("clr_cap_valid",  32'(rsp_valid),    32'd1);
        chk("clr_cap_sticky", 32'(sticky_flags), 32'h003);
        chk("clr_cap_z",      rsp_z,             32'hFFFF_FFFF);
        cycle();

        // Reset during WAIT abandons the command
        issue(OP_CADD, 32'h0005_0005, 32'h0001_0001, 1'b0);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstw_acc",       acc,            32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (rsp_valid === 1'b1) seen++;
        end
        chk("rstw_no_rsp", 32'(seen), 32'd0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            do_cmd(OP_CDIV, 32'($urandom), 32'h0, 1'b0, lat);
            cycle();
            if (i == 254) chk("err_at_255", 32'(err_count), 32'd255);
        end
        chk("err_saturated", 32'(err_count), 32'd255);

        // Randomized traffic
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 800; i++) begin
            cmd_valid   = 1'($urandom_range(0, 1));
            cmd_opcode  = 4'($urandom);
            cmd_z1      = $urandom;
            cmd_z2      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            cmd_use_acc = 1'($urandom_range(0, 1));
            rsp_ready   = ($urandom_range(0, 3) != 0);
            sticky_clr  = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0; cmd_valid = 1'b0; sticky_clr = 1'b0; rsp_ready = 1'b1;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
